// File: rtl/ibex_compressed_encoder_pkg.sv
// ibex_compressed_encoder_pkg: RV32 opcode constants and fixed RVC encodings shared by the encoder files
package ibex_compressed_encoder_pkg;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;
  localparam logic [15:0] C_NOP     = 16'h0001;
  localparam logic [15:0] C_EBREAK  = 16'h9002;
endpackage

// File: rtl/ibex_compressed_encoder_core.sv
// ibex_compressed_encoder_core: combinational RV32 -> RVC re-encoder (instr in; cmp = compressible, c16 = 16-bit form out)
module ibex_compressed_encoder_core
  import ibex_compressed_encoder_pkg::*;
#(
  parameter bit CompressEn = 1'b1
) (
  input  logic [31:0] instr,
  output logic        cmp,
  output logic [15:0] c16
);
  logic [6:0] opc, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [11:0] imm_i, imm_s;
  logic imm6, is_addi, is_add, is_jalr;
  logic c_addi, c_li, c_slli, c_mv, c_add, c_jr, c_jalr, c_ebreak, c_lw, c_sw;
  assign opc   = instr[6:0];
  assign rd    = instr[11:7];
  assign f3    = instr[14:12];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign f7    = instr[31:25];
  assign imm_i = instr[31:20];
  assign imm_s = {instr[31:25], instr[11:7]};
  // imm fits the 6-bit signed field when bits [11:5] are a pure sign extension
  assign imm6    = imm_i[11:5] == '0 || imm_i[11:5] == '1;
  assign is_addi = opc == OPC_OP_IMM && f3 == 3'b000 && rd != 0;
  assign is_add  = opc == OPC_OP && f3 == 3'b000 && f7 == 0 && rd != 0 && rs2 != 0;
  assign is_jalr = opc == OPC_JALR && f3 == 3'b000 && imm_i == 0 && rs1 != 0;
  assign c_addi  = is_addi && rs1 == rd && imm_i != 0 && imm6;
  assign c_li    = is_addi && rs1 == 0 && imm6;
  assign c_slli  = opc == OPC_OP_IMM && f3 == 3'b001 && f7 == 0 && rd != 0 && rs1 == rd && rs2 != 0;
  assign c_mv    = is_add && rs1 == 0;
  assign c_add   = is_add && rs1 == rd;
  assign c_jr    = is_jalr && rd == 0;
  assign c_jalr  = is_jalr && rd == 5'd1;
  assign c_ebreak = instr == {12'h001, 13'h0, OPC_SYSTEM};
  // compressed loads/stores only reach x8..x15 and word offsets below 128
  assign c_lw = opc == OPC_LOAD && f3 == 3'b010 && rd[4:3] == 2'b01 && rs1[4:3] == 2'b01 &&
                imm_i[11:7] == 0 && imm_i[1:0] == 0;
  assign c_sw = opc == OPC_STORE && f3 == 3'b010 && rs2[4:3] == 2'b01 && rs1[4:3] == 2'b01 &&
                imm_s[11:7] == 0 && imm_s[1:0] == 0;
  assign cmp = CompressEn && (c_addi || c_li || c_slli || c_mv || c_add || c_jr || c_jalr ||
                              c_ebreak || c_lw || c_sw);
  always_comb begin
    c16 = c_addi   ? {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01} :
          c_li     ? {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01} :
          c_slli   ? {3'b000, 1'b0, rd, rs2, 2'b10} :
          c_mv     ? {4'b1000, rd, rs2, 2'b10} :
          c_add    ? {4'b1001, rd, rs2, 2'b10} :
          c_jr     ? {4'b1000, rs1, 5'b0, 2'b10} :
          c_jalr   ? {4'b1001, rs1, 5'b0, 2'b10} :
          c_ebreak ? C_EBREAK :
          c_lw     ? {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00} :
          c_sw     ? {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00} :
                     16'h0000;
  end
endmodule

// File: rtl/ibex_compressed_encoder.sv
// ibex_compressed_encoder: compresses RV32 instructions and packs the 16/32-bit stream into LE words (valid/ready in and out, flush_i drains, idle_o when empty)
module ibex_compressed_encoder
  import ibex_compressed_encoder_pkg::*;
#(
  parameter bit CompressEn = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_instr_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_word_o,
  output logic        idle_o
);
  logic [15:0] hold_q, c16;
  logic hold_valid_q, flush_pend_q, cmp, accept, slot_free;
  ibex_compressed_encoder_core #(.CompressEn(CompressEn)) u_core (
    .instr(in_instr_i),
    .cmp  (cmp),
    .c16  (c16)
  );
  assign slot_free  = !out_valid_o || out_ready_i;
  assign in_ready_o = !flush_pend_q && slot_free;
  assign accept     = in_valid_i && in_ready_o;
  assign idle_o     = !hold_valid_q && !out_valid_o && !flush_pend_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o  <= 1'b0;
      out_word_o   <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      if (out_ready_i) out_valid_o <= 1'b0;
      if (accept) begin
        if (cmp && !hold_valid_q) begin
          hold_q       <= c16;
          hold_valid_q <= 1'b1;
        end else begin
          out_valid_o <= 1'b1;
          out_word_o  <= cmp ? {c16, hold_q} : hold_valid_q ? {in_instr_i[15:0], hold_q} : in_instr_i;
          // a 32-bit instruction straddling the word boundary leaves its upper half held
          if (cmp) hold_valid_q <= 1'b0;
          if (!cmp && hold_valid_q) hold_q <= in_instr_i[31:16];
        end
      end else if (flush_pend_q && slot_free) begin
        if (hold_valid_q) begin
          out_word_o   <= {C_NOP, hold_q};
          out_valid_o  <= 1'b1;
          hold_valid_q <= 1'b0;
        end
        flush_pend_q <= 1'b0;
      end
      if (flush_i) flush_pend_q <= 1'b1;
    end
  end
endmodule
